// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller: FSM encoding,
// the bundled pause/bubble control word and small helpers.
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        PCTL_RUN      = 2'd0,
        PCTL_MEM_WAIT = 2'd1,
        PCTL_MD_WAIT  = 2'd2
    } pctl_state_e;

    typedef struct packed {
        logic pc_pause;
        logic if_id_pause;
        logic if_id_bubble;
        logic id_ex_pause;
        logic id_ex_bubble;
        logic ex_mem_pause;
        logic ex_mem_bubble;
        logic mem_wb_pause;
        logic mem_wb_bubble;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_IDLE = '{default: 1'b0};

    // While in reset every stage is fed bubbles and nothing is held.
    localparam pipe_ctl_t CTL_RESET = '{
        pc_pause:      1'b0,
        if_id_pause:   1'b0,
        if_id_bubble:  1'b1,
        id_ex_pause:   1'b0,
        id_ex_bubble:  1'b1,
        ex_mem_pause:  1'b0,
        ex_mem_bubble: 1'b1,
        mem_wb_pause:  1'b0,
        mem_wb_bubble: 1'b1
    };

    function automatic logic src_hit(
        input logic                  use_src,
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] dst
    );
        return use_src && (src == dst);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads
// the destination of a load still sitting in EX.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    output logic                  load_use
);

    // x0 is never a real dependency, so a load to x0 cannot cause a hazard
    always_comb begin
        load_use = 1'b0;
        if (ex_is_load && (ex_rd != {REG_ADDR_W{1'b0}})) begin
            load_use = src_hit(id_use_rs1, id_rs1, ex_rd) ||
                       src_hit(id_use_rs2, id_rs2, ex_rd);
        end else begin
            load_use = 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller: sole source of pause/bubble control for the
// four pipeline registers and the PC, plus stall/flush performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    input  logic                  branch_taken,
    input  logic                  md_start,
    input  logic                  md_done,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_pause,
    output logic                  if_id_pause,
    output logic                  if_id_bubble,
    output logic                  id_ex_pause,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_pause,
    output logic                  ex_mem_bubble,
    output logic                  mem_wb_pause,
    output logic                  mem_wb_bubble,
    output logic [XLEN-1:0]       stall_cycles,
    output logic [XLEN-1:0]       flush_count
);

    localparam logic [XLEN-1:0] CNT_ONE = {{(XLEN-1){1'b0}}, 1'b1};

    pctl_state_e     state_r;
    pctl_state_e     state_nxt_s;
    logic            pending_flush_r;
    logic            pending_nxt_s;
    logic            md_busy_r;
    logic            md_busy_nxt_s;
    logic [XLEN-1:0] stall_cycles_r;
    logic [XLEN-1:0] flush_count_r;

    logic            load_use_s;
    logic            mem_stall_s;
    logic            md_stall_s;
    logic            stalled_s;
    logic            flush_s;
    pipe_ctl_t       ctl_s;
    pipe_ctl_t       ctl_out_s;

    hazard_detect u_hazard_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .load_use   (load_use_s)
    );

    // Stall sources; a memory wait masks a concurrent mul/div wait
    always_comb begin
        mem_stall_s = 1'b0;
        md_stall_s  = 1'b0;
        if (state_r == PCTL_MEM_WAIT) begin
            mem_stall_s = ~mem_ready;
        end else begin
            mem_stall_s = mem_req & ~mem_ready;
        end
        if (state_r == PCTL_MD_WAIT) begin
            md_stall_s = ~mem_stall_s;
        end else begin
            md_stall_s = 1'b0;
        end
        stalled_s = mem_stall_s | md_stall_s;
        flush_s   = ~stalled_s & (branch_taken | pending_flush_r);
    end

    // Priority mux: memory wait, mul/div wait, flush, load-use
    always_comb begin
        ctl_s = CTL_IDLE;
        if (mem_stall_s) begin
            ctl_s.pc_pause      = 1'b1;
            ctl_s.if_id_pause   = 1'b1;
            ctl_s.id_ex_pause   = 1'b1;
            ctl_s.ex_mem_pause  = 1'b1;
            ctl_s.mem_wb_bubble = 1'b1;
        end else if (md_stall_s) begin
            ctl_s.pc_pause      = 1'b1;
            ctl_s.if_id_pause   = 1'b1;
            ctl_s.id_ex_pause   = 1'b1;
            ctl_s.ex_mem_bubble = 1'b1;
        end else if (flush_s) begin
            ctl_s.if_id_bubble  = 1'b1;
            ctl_s.id_ex_bubble  = 1'b1;
        end else if ((state_r == PCTL_RUN) && load_use_s) begin
            ctl_s.pc_pause      = 1'b1;
            ctl_s.if_id_pause   = 1'b1;
            ctl_s.id_ex_bubble  = 1'b1;
        end else begin
            ctl_s = CTL_IDLE;
        end
    end

    // Next-state, outstanding mul/div and deferred-flush bookkeeping
    always_comb begin
        md_busy_nxt_s = (md_busy_r | ((state_r == PCTL_RUN) && md_start)) & ~md_done;
        if (stalled_s) begin
            pending_nxt_s = pending_flush_r | branch_taken;
        end else begin
            pending_nxt_s = 1'b0;
        end
        state_nxt_s = state_r;
        if (mem_stall_s) begin
            state_nxt_s = PCTL_MEM_WAIT;
        end else begin
            case (state_r)
                PCTL_RUN:      state_nxt_s = (md_start && !md_done) ? PCTL_MD_WAIT : PCTL_RUN;
                PCTL_MEM_WAIT: state_nxt_s = md_busy_nxt_s ? PCTL_MD_WAIT : PCTL_RUN;
                PCTL_MD_WAIT:  state_nxt_s = md_done ? PCTL_RUN : PCTL_MD_WAIT;
                default:       state_nxt_s = PCTL_RUN;
            endcase
        end
    end

    // FSM state, flags and performance counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= PCTL_RUN;
            pending_flush_r <= 1'b0;
            md_busy_r       <= 1'b0;
            stall_cycles_r  <= {XLEN{1'b0}};
            flush_count_r   <= {XLEN{1'b0}};
        end else begin
            state_r         <= state_nxt_s;
            pending_flush_r <= pending_nxt_s;
            md_busy_r       <= md_busy_nxt_s;
            if (ctl_s.pc_pause) begin
                stall_cycles_r <= stall_cycles_r + CNT_ONE;
            end
            if (flush_s) begin
                flush_count_r <= flush_count_r + CNT_ONE;
            end
        end
    end

    // Reset forces bubbles everywhere regardless of the pipeline state
    always_comb begin
        if (!reset_n) begin
            ctl_out_s = CTL_RESET;
        end else begin
            ctl_out_s = ctl_s;
        end
    end

    assign pc_pause      = ctl_out_s.pc_pause;
    assign if_id_pause   = ctl_out_s.if_id_pause;
    assign if_id_bubble  = ctl_out_s.if_id_bubble;
    assign id_ex_pause   = ctl_out_s.id_ex_pause;
    assign id_ex_bubble  = ctl_out_s.id_ex_bubble;
    assign ex_mem_pause  = ctl_out_s.ex_mem_pause;
    assign ex_mem_bubble = ctl_out_s.ex_mem_bubble;
    assign mem_wb_pause  = ctl_out_s.mem_wb_pause;
    assign mem_wb_bubble = ctl_out_s.mem_wb_bubble;
    assign stall_cycles  = stall_cycles_r;
    assign flush_count   = flush_count_r;

endmodule
